mat_mult_nxn: RTL and testbench

MAT_MULT_NXN -- requirements
Module: mat_mult_nxn

---
 rtl/mat_mult_pkg.sv | 33 +++
 rtl/mat_mult_nxn_if.sv | 35 +++
 rtl/mat_mult_rescale.sv | 65 ++++++
 rtl/mat_mult_nxn.sv | 173 +++++++++++++++++
 tb/tb_mat_mult_nxn.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mat_mult_pkg
// Description : Shared FSM state type and width helpers for the NxN
//               fixed-point matrix multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mat_mult_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      ACCUM  = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   // Accumulator width: full product plus growth for N summed products.
   function automatic int acc_w(input int n, input int data_w);
      return 2 * data_w + $clog2(n);
   endfunction

   // Width of the pass counter and the per-pass load index (0..N-1).
   function automatic int k_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width of the result index (0..N*N-1).
   function automatic int idx_w(input int n);
      return $clog2(n * n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mat_mult_nxn_if.sv
`default_nettype none
// ============================================================================
// Module      : mat_mult_nxn_if
// Description : Operand load channels, result channel and status of the
//               NxN matrix multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface mat_mult_nxn_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] i_a_num;
   logic              i_a_num_valid;
   logic              o_a_read;
   logic [DATA_W-1:0] i_b_num;
   logic              i_b_num_valid;
   logic              o_b_read;
   logic [DATA_W-1:0] o_res_data;
   logic              o_res_valid;
   logic              i_res_ready;
   logic              o_res_last;
   logic              o_busy;

   // Producer of operands / consumer of results.
   modport master (
      output i_a_num, i_a_num_valid, i_b_num, i_b_num_valid, i_res_ready,
      input  o_a_read, o_b_read, o_res_data, o_res_valid, o_res_last, o_busy
   );

   // The multiplier itself.
   modport slave (
      input  i_a_num, i_a_num_valid, i_b_num, i_b_num_valid, i_res_ready,
      output o_a_read, o_b_read, o_res_data, o_res_valid, o_res_last, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/mat_mult_rescale.sv
`default_nettype none
// ============================================================================
// Module      : mat_mult_rescale
// Description : Combinational fixed-point rescale of an accumulator value:
//               optional round-half-up, arithmetic shift by FRAC_W, then
//               saturate or wrap to DATA_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_mult_rescale #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 18,
   parameter int FRAC_W = 4,
   parameter int SAT    = 1,
   parameter int ROUND  = 1
) (
   input  logic signed [ACC_W-1:0]  i_acc,
   output logic        [DATA_W-1:0] o_data
);

   // One guard bit so the rounding bias can never overflow.
   localparam int c_ext_w = ACC_W + 1;
   localparam logic signed [c_ext_w-1:0] c_max =
      {{(c_ext_w-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [c_ext_w-1:0] c_min = ~c_max;

   logic signed [c_ext_w-1:0] w_ext;
   logic signed [c_ext_w-1:0] w_biased;
   logic signed [c_ext_w-1:0] w_shift;

   assign w_ext = {i_acc[ACC_W-1], i_acc};

   generate
      if (ROUND != 0 && FRAC_W > 0) begin : g_round
         localparam logic signed [c_ext_w-1:0] c_half = c_ext_w'(1) << (FRAC_W - 1);
         assign w_biased = w_ext + c_half;
      end else begin : g_trunc
         assign w_biased = w_ext;
      end
   endgenerate

   // Arithmetic shift gives floor division, i.e. truncation toward -inf.
   assign w_shift = w_biased >>> FRAC_W;

   generate
      if (SAT != 0) begin : g_sat
         // Clamp into the signed DATA_W range.
         always_comb begin
            if (w_shift > c_max) begin
               o_data = c_max[DATA_W-1:0];
            end else if (w_shift < c_min) begin
               o_data = c_min[DATA_W-1:0];
            end else begin
               o_data = w_shift[DATA_W-1:0];
            end
         end
      end else begin : g_wrap
         // High bits are intentionally discarded in wrap mode.
         logic w_unused_hi;
         assign w_unused_hi = ^w_shift[c_ext_w-1:DATA_W];
         assign o_data      = w_shift[DATA_W-1:0];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/mat_mult_nxn.sv
`default_nettype none
// ============================================================================
// Module      : mat_mult_nxn
// Description : NxN signed fixed-point matrix multiplier built as N
//               outer-product passes (column of A x row of B), followed by a
//               row-major result stream with valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_mult_nxn
   import mat_mult_pkg::*;
#(
   parameter int N      = 3,
   parameter int DATA_W = 8,
   parameter int FRAC_W = 4,
   parameter int SAT    = 1,
   parameter int ROUND  = 1
) (
   input logic           i_clk,
   input logic           i_rst,
   mat_mult_nxn_if.slave bus
);

   localparam int c_acc_w = acc_w(N, DATA_W);
   localparam int c_k_w   = k_w(N);
   localparam int c_idx_w = idx_w(N);
   localparam int c_nn    = N * N;

   localparam logic [c_k_w-1:0]   c_k_last     = c_k_w'(N - 1);
   localparam logic [c_k_w-1:0]   c_k_one      = c_k_w'(1);
   localparam logic [c_idx_w-1:0] c_out_last   = c_idx_w'(c_nn - 1);
   localparam logic [c_idx_w-1:0] c_out_penult = c_idx_w'(c_nn - 2);
   localparam logic [c_idx_w-1:0] c_out_one    = c_idx_w'(1);

   state_t                      r_state;
   logic [c_k_w-1:0]            r_k;
   logic [c_k_w-1:0]            r_lidx;
   logic [c_idx_w-1:0]          r_oidx;
   logic signed [DATA_W-1:0]    r_a_col [N];
   logic signed [DATA_W-1:0]    r_b_row [N];
   logic signed [c_acc_w-1:0]   r_acc   [c_nn];
   logic                        r_a_read;
   logic                        r_b_read;
   logic                        r_res_valid;
   logic                        r_res_last;
   logic                        r_busy;

   logic signed [2*DATA_W-1:0]  w_prod  [N][N];
   logic signed [c_acc_w-1:0]   w_acc_sel;
   logic [DATA_W-1:0]           w_res_data;

   // Full-precision outer product of the current A column and B row.
   generate
      for (genvar gr = 0; gr < N; gr++) begin : g_row
         for (genvar gc = 0; gc < N; gc++) begin : g_col
            assign w_prod[gr][gc] = r_a_col[gr] * r_b_row[gc];
         end
      end
   endgenerate

   assign w_acc_sel = r_acc[r_oidx];

   mat_mult_rescale #(
      .DATA_W (DATA_W),
      .ACC_W  (c_acc_w),
      .FRAC_W (FRAC_W),
      .SAT    (SAT),
      .ROUND  (ROUND)
   ) u_rescale (
      .i_acc  (w_acc_sel),
      .o_data (w_res_data)
   );

   // Control flags come straight from registers, never from inputs.
   assign bus.o_a_read    = r_a_read;
   assign bus.o_b_read    = r_b_read;
   assign bus.o_res_valid = r_res_valid;
   assign bus.o_res_last  = r_res_last;
   assign bus.o_busy      = r_busy;
   assign bus.o_res_data  = w_res_data;

   // Job sequencer: load A column, load B row, accumulate, repeat N times,
   // then stream the rescaled results.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= LOAD_A;
         r_k         <= '0;
         r_lidx      <= '0;
         r_oidx      <= '0;
         r_a_read    <= 1'b1;
         r_b_read    <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_last  <= 1'b0;
         r_busy      <= 1'b0;
         for (int i = 0; i < N; i++) begin
            r_a_col[i] <= '0;
            r_b_row[i] <= '0;
         end
         for (int i = 0; i < c_nn; i++) begin
            r_acc[i] <= '0;
         end
      end else begin
         case (r_state)
            LOAD_A: begin
               if (bus.i_a_num_valid && r_a_read) begin
                  r_a_col[r_lidx] <= bus.i_a_num;
                  r_busy          <= 1'b1;
                  if (r_lidx == c_k_last) begin
                     r_lidx   <= '0;
                     r_a_read <= 1'b0;
                     r_b_read <= 1'b1;
                     r_state  <= LOAD_B;
                  end else begin
                     r_lidx <= r_lidx + c_k_one;
                  end
               end
            end
            LOAD_B: begin
               if (bus.i_b_num_valid && r_b_read) begin
                  r_b_row[r_lidx] <= bus.i_b_num;
                  if (r_lidx == c_k_last) begin
                     r_lidx   <= '0;
                     r_b_read <= 1'b0;
                     r_state  <= ACCUM;
                  end else begin
                     r_lidx <= r_lidx + c_k_one;
                  end
               end
            end
            ACCUM: begin
               for (int r = 0; r < N; r++) begin
                  for (int c = 0; c < N; c++) begin
                     r_acc[r*N+c] <= r_acc[r*N+c] + c_acc_w'(w_prod[r][c]);
                  end
               end
               if (r_k == c_k_last) begin
                  r_oidx      <= '0;
                  r_res_valid <= 1'b1;
                  r_res_last  <= 1'b0;
                  r_state     <= OUTPUT;
               end else begin
                  r_k      <= r_k + c_k_one;
                  r_a_read <= 1'b1;
                  r_state  <= LOAD_A;
               end
            end
            OUTPUT: begin
               if (bus.i_res_ready && r_res_valid) begin
                  if (r_oidx == c_out_last) begin
                     for (int i = 0; i < c_nn; i++) begin
                        r_acc[i] <= '0;
                     end
                     r_k         <= '0;
                     r_oidx      <= '0;
                     r_res_valid <= 1'b0;
                     r_res_last  <= 1'b0;
                     r_a_read    <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= LOAD_A;
                  end else begin
                     r_oidx     <= r_oidx + c_out_one;
                     r_res_last <= (r_oidx == c_out_penult);
                  end
               end
            end
            default: begin
               r_state <= LOAD_A;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mat_mult_nxn.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_mult_nxn
// Description : Scoreboard bench for mat_mult_nxn (N=3, DATA_W=8, FRAC_W=4)
//               driving three builds in lockstep: saturate+round,
//               wrap+round, saturate+truncate.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_mult_nxn;

   logic       clk;
   logic       rst;
   logic [7:0] a_num;
   logic       a_valid;
   logic [7:0] b_num;
   logic       b_valid;
   logic       res_ready;

   int n_checks = 0;
   int n_fail   = 0;
   int tot [3];
   int pos      = 0;
   bit stall_armed = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] q2[$];

   logic [7:0] ja [9];
   logic [7:0] jb [9];
   logic [7:0] e0 [9];
   logic [7:0] e1 [9];
   logic [7:0] e2 [9];

   mat_mult_nxn_if #(.DATA_W(8)) bus0 ();
   mat_mult_nxn_if #(.DATA_W(8)) bus1 ();
   mat_mult_nxn_if #(.DATA_W(8)) bus2 ();

   assign bus0.i_a_num = a_num;  assign bus0.i_a_num_valid = a_valid;
   assign bus0.i_b_num = b_num;  assign bus0.i_b_num_valid = b_valid;
   assign bus0.i_res_ready = res_ready;
   assign bus1.i_a_num = a_num;  assign bus1.i_a_num_valid = a_valid;
   assign bus1.i_b_num = b_num;  assign bus1.i_b_num_valid = b_valid;
   assign bus1.i_res_ready = res_ready;
   assign bus2.i_a_num = a_num;  assign bus2.i_a_num_valid = a_valid;
   assign bus2.i_b_num = b_num;  assign bus2.i_b_num_valid = b_valid;
   assign bus2.i_res_ready = res_ready;

   mat_mult_nxn #(.N(3), .DATA_W(8), .FRAC_W(4), .SAT(1), .ROUND(1))
      u_dut_sat (.i_clk(clk), .i_rst(rst), .bus(bus0));
   mat_mult_nxn #(.N(3), .DATA_W(8), .FRAC_W(4), .SAT(0), .ROUND(1))
      u_dut_wrap (.i_clk(clk), .i_rst(rst), .bus(bus1));
   mat_mult_nxn #(.N(3), .DATA_W(8), .FRAC_W(4), .SAT(1), .ROUND(0))
      u_dut_trunc (.i_clk(clk), .i_rst(rst), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_idle(input string nm);
      chk({nm, "_sat"},   16'({bus0.o_a_read, bus0.o_b_read, bus0.o_res_valid, bus0.o_res_last, bus0.o_busy}), 16'h0010);
      chk({nm, "_wrap"},  16'({bus1.o_a_read, bus1.o_b_read, bus1.o_res_valid, bus1.o_res_last, bus1.o_busy}), 16'h0010);
      chk({nm, "_trunc"}, 16'({bus2.o_a_read, bus2.o_b_read, bus2.o_res_valid, bus2.o_res_last, bus2.o_busy}), 16'h0010);
   endtask

   // Hand-computed stimulus and per-build expected results.
   task automatic set_job(input int kind);
      for (int i = 0; i < 9; i++) begin
         case (kind)
            1: begin
               ja[i] = (i % 4 == 0) ? 8'h10 : 8'h00;
               jb[i] = 8'(i + 1);
               e0[i] = 8'(i + 1); e1[i] = 8'(i + 1); e2[i] = 8'(i + 1);
            end
            2: begin
               ja[i] = 8'h7F; jb[i] = 8'h7F;
               e0[i] = 8'h7F; e1[i] = 8'hD0; e2[i] = 8'h7F;
            end
            3: begin
               ja[i] = 8'h80; jb[i] = 8'h7F;
               e0[i] = 8'h80; e1[i] = 8'h18; e2[i] = 8'h80;
            end
            default: begin
               ja[i] = 8'h00; jb[i] = 8'h00;
               e0[i] = 8'h00; e1[i] = 8'h00; e2[i] = 8'h00;
            end
         endcase
      end
      if (kind == 4) begin
         ja[0] = 8'h01; jb[0] = 8'h08;
         e0[0] = 8'h01; e1[0] = 8'h01; e2[0] = 8'h00;
      end
   endtask

   // Present one A element with garbage on B; returns once a transfer is due.
   task automatic put_a(input logic [7:0] v);
      int t = 0;
      do begin
         @(negedge clk);
         a_num = v; a_valid = 1'b1; b_num = 8'hAA; b_valid = 1'b1;
         t++;
      end while (!bus0.o_a_read && t < 200);
      chk("a_accept_timeout", 16'(bus0.o_a_read), 16'h0001);
   endtask

   task automatic put_b(input logic [7:0] v);
      int t = 0;
      do begin
         @(negedge clk);
         b_num = v; b_valid = 1'b1; a_num = 8'h55; a_valid = 1'b1;
         t++;
      end while (!bus0.o_b_read && t < 200);
      chk("b_accept_timeout", 16'(bus0.o_b_read), 16'h0001);
   endtask

   task automatic run_job();
      for (int i = 0; i < 9; i++) begin
         q0.push_back({i == 8, e0[i]});
         q1.push_back({i == 8, e1[i]});
         q2.push_back({i == 8, e2[i]});
      end
      for (int k = 0; k < 3; k++) begin
         for (int r = 0; r < 3; r++) put_a(ja[r*3+k]);
         for (int c = 0; c < 3; c++) put_b(jb[k*3+c]);
      end
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", 16'(q0.size() + q1.size() + q2.size()), 16'h0000);
   endtask

   task automatic chk_out(input int d, input logic v, input logic l, input logic [7:0] x);
      logic [8:0] e;
      bit ok;
      ok = 1'b1; e = '0;
      case (d)
         0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
         1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
         default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
      endcase
      tot[d]++;
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL out%0d_unexpected: got %h with nothing expected", d, {l, x});
      end else begin
         chk($sformatf("out%0d_valid_last_data", d), 16'({v, l, x}), 16'({1'b1, e}));
      end
   endtask

   // Monitor: owns i_res_ready, stalls once when armed, checks each transfer.
   initial begin : mon
      logic [9:0] h0, h1, h2;
      res_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && bus0.o_res_valid) begin
            if (stall_armed && pos == 4) begin
               stall_armed = 0;
               res_ready = 1'b0;
               h0 = {bus0.o_res_valid, bus0.o_res_last, bus0.o_res_data};
               h1 = {bus1.o_res_valid, bus1.o_res_last, bus1.o_res_data};
               h2 = {bus2.o_res_valid, bus2.o_res_last, bus2.o_res_data};
               for (int s = 0; s < 5; s++) begin
                  @(negedge clk);
                  chk("stall_hold_sat",   16'({bus0.o_res_valid, bus0.o_res_last, bus0.o_res_data}), 16'(h0));
                  chk("stall_hold_wrap",  16'({bus1.o_res_valid, bus1.o_res_last, bus1.o_res_data}), 16'(h1));
                  chk("stall_hold_trunc", 16'({bus2.o_res_valid, bus2.o_res_last, bus2.o_res_data}), 16'(h2));
               end
               res_ready = 1'b1;
            end
            chk_out(0, bus0.o_res_valid, bus0.o_res_last, bus0.o_res_data);
            chk_out(1, bus1.o_res_valid, bus1.o_res_last, bus1.o_res_data);
            chk_out(2, bus2.o_res_valid, bus2.o_res_last, bus2.o_res_data);
            pos = (pos == 8) ? 0 : pos + 1;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      tot[0] = 0; tot[1] = 0; tot[2] = 0;
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_num = '0; b_num = '0;
      repeat (3) @(negedge clk);
      check_idle("in_reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("after_reset");

      set_job(1); run_job();
      set_job(2); run_job();
      set_job(3); run_job();
      set_job(4); run_job();

      wait_drain();
      stall_armed = 1;
      set_job(1); run_job();

      // Abort a job during LOAD_B of the second pass.
      wait_drain();
      set_job(1);
      for (int r = 0; r < 3; r++) put_a(8'h33);
      for (int c = 0; c < 3; c++) put_b(8'h44);
      for (int r = 0; r < 3; r++) put_a(8'h66);
      put_b(8'h77);
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      chk("busy_mid_job", 16'(bus0.o_busy), 16'h0001);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("after_abort");
      run_job();

      wait_drain();
      chk("total_sat",   16'(tot[0]), 16'd54);
      chk("total_wrap",  16'(tot[1]), 16'd54);
      chk("total_trunc", 16'(tot[2]), 16'd54);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
